usb3_hp_tx_sched: RTL and testbench

Link-layer header-packet transmit scheduler. It drains the 8-deep 96-bit header-packet TX FIFO and stamps each header with a 3-bit Header Sequence Number. It gates transmission on remote Rx header-buffer credits and holds every unacknowledged header in a 4-entry retry buffer until LGOOD arrives. On LBAD or on link re-activation it replays all unacknowledged headers, oldest first.

---
 rtl/usb3_hp_tx_sched_pkg.sv | 21 ++
 rtl/usb3_hp_retry_buf.sv | 62 ++++++
 rtl/usb3_hp_tx_sched.sv | 153 +++++++++++++++
 tb/tb_usb3_hp_tx_sched.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb3_hp_tx_sched_pkg.sv
// Shared constants, header entry type and FSM encoding for the USB3 link-layer
// header-packet transmit scheduler.
package usb3_hp_tx_sched_pkg;

  localparam int HP_W         = 96;
  localparam int SEQ_W        = 3;
  localparam int MAX_INFLIGHT = 4;
  localparam int CNT_W        = 3;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_LOAD   = 3'd2;
  localparam logic [2:0] ST_SEND   = 3'd3;
  localparam logic [2:0] ST_REPLAY = 3'd4;

  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [HP_W-1:0]  data;
  } hp_entry_t;

endpackage

// File: rtl/usb3_hp_retry_buf.sv
// Retry buffer: holds every unacknowledged header with its sequence number,
// plus a replay cursor that walks head-to-tail and never falls behind the head.
module usb3_hp_retry_buf
  import usb3_hp_tx_sched_pkg::*;
#(
  parameter int DEPTH = MAX_INFLIGHT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  hp_entry_t        push_entry,
  input  logic             release_head,
  input  logic             replay_start,
  input  logic             take,
  output hp_entry_t        cur_entry,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] remaining
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  hp_entry_t        mem [0:(1<<PTR_W)-1];
  logic [PTR_W-1:0] head, tail, cursor;
  logic [PTR_W-1:0] head_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic             cursor_at_head;

  assign head_nxt  = head + PTR_W'(release_head);
  assign count_nxt = count + CNT_W'(push) - CNT_W'(release_head);

  // The cursor sits on the head only while nothing of this replay round has been offered.
  assign cursor_at_head = (remaining == count) && (remaining != '0);

  // NOTE: storage is deliberately not reset; occupancy lives in the counters, so only they need rst_n.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= push_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head      <= '0;
      tail      <= '0;
      cursor    <= '0;
      count     <= '0;
      remaining <= '0;
    end else begin
      head  <= head_nxt;
      count <= count_nxt;
      if (push) tail <= tail + PTR_W'(1);
      if (replay_start) begin
        cursor    <= head_nxt;
        remaining <= count_nxt;
      end else if (take || (release_head && cursor_at_head)) begin
        cursor    <= cursor + PTR_W'(1);
        remaining <= remaining - CNT_W'(1);
      end
    end
  end

  assign cur_entry = mem[cursor];

endmodule

// File: rtl/usb3_hp_tx_sched.sv
// Header-packet TX scheduler: fetches headers from the TX FIFO, stamps sequence
// numbers, gates on remote credits and replays unacknowledged headers on LBAD/link re-entry.
module usb3_hp_tx_sched
  import usb3_hp_tx_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hp_empty,
  output logic             hp_rd,
  input  logic [31:0]      hp_word_0_q,
  input  logic [31:0]      hp_word_1_q,
  input  logic [31:0]      hp_word_2_q,
  output logic             tx_hp_valid,
  input  logic             tx_hp_ready,
  output logic [31:0]      tx_hp_word_0,
  output logic [31:0]      tx_hp_word_1,
  output logic [31:0]      tx_hp_word_2,
  output logic [SEQ_W-1:0] tx_hp_seq,
  input  logic             lgood_valid,
  input  logic [SEQ_W-1:0] lgood_seq,
  input  logic             lbad_valid,
  input  logic             lcrd_valid,
  input  logic             credit_init,
  input  logic             link_active,
  output logic [CNT_W-1:0] inflight_cnt,
  output logic [CNT_W-1:0] credit_cnt,
  output logic             seq_err
);

  logic [2:0]       state, state_nxt;
  logic [SEQ_W-1:0] tx_seq, ack_seq;
  logic             link_active_d, replay_pend;
  logic             offer_valid;
  hp_entry_t        offer_q, cur_entry, load_entry;
  logic [CNT_W-1:0] replay_rem;
  logic             load, handshake, lgood_ok, replay_set, replay_now, can_fetch;
  logic             take, replay_start;

  assign load       = (state == ST_LOAD);
  assign handshake  = offer_valid && tx_hp_ready;
  assign lgood_ok   = lgood_valid && (lgood_seq == ack_seq) && (inflight_cnt != '0);
  assign replay_set = lbad_valid || (link_active && !link_active_d && (inflight_cnt != '0));
  // A replay request seen this very cycle must already block a new fetch.
  assign replay_now = replay_pend || replay_set;
  assign can_fetch  = link_active && !hp_empty && (credit_cnt != '0) &&
                      (inflight_cnt < CNT_W'(MAX_INFLIGHT)) && !replay_now;
  assign load_entry = '{seq: tx_seq, data: {hp_word_2_q, hp_word_1_q, hp_word_0_q}};

  usb3_hp_retry_buf #(.DEPTH(MAX_INFLIGHT)) u_retry_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .push         (load),
    .push_entry   (load_entry),
    .release_head (lgood_ok),
    .replay_start (replay_start),
    .take         (take),
    .cur_entry    (cur_entry),
    .count        (inflight_cnt),
    .remaining    (replay_rem)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_nxt    = state;
    replay_start = 1'b0;
    take         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (replay_now) begin
          state_nxt    = ST_REPLAY;
          replay_start = 1'b1;
        end else if (can_fetch) begin
          state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_SEND;
      ST_SEND: begin
        if (handshake) begin
          state_nxt    = replay_now ? ST_REPLAY : ST_IDLE;
          replay_start = replay_now;
        end
      end
      ST_REPLAY: begin
        // Decisions happen only when no header is held on the interface.
        if (!offer_valid || handshake) begin
          if (replay_now)              replay_start = 1'b1;
          else if (replay_rem == '0)   state_nxt    = ST_IDLE;
          else if (link_active)        take         = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      tx_seq        <= '0;
      ack_seq       <= '0;
      link_active_d <= 1'b0;
      replay_pend   <= 1'b0;
      seq_err       <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state         <= state_nxt;
      link_active_d <= link_active;
      seq_err       <= lgood_valid && !lgood_ok;
      if (lgood_ok) ack_seq <= ack_seq + SEQ_W'(1);
      if ((state == ST_SEND) && handshake) tx_seq <= tx_seq + SEQ_W'(1);
      if (replay_start)    replay_pend <= 1'b0;
      else if (replay_set) replay_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      offer_valid <= 1'b0;
      offer_q     <= '0;
    end else if (load) begin
      offer_valid <= 1'b1;
      offer_q     <= load_entry;
    end else if (take) begin
      offer_valid <= 1'b1;
      offer_q     <= cur_entry;
    end else if (handshake) begin
      offer_valid <= 1'b0;
    end
  end

  // credit_init wins; a same-cycle return and consume cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_cnt <= CNT_W'(MAX_INFLIGHT);
    end else if (credit_init) begin
      credit_cnt <= CNT_W'(MAX_INFLIGHT);
    end else begin
      case ({lcrd_valid, load})
        2'b10:   if (credit_cnt < CNT_W'(MAX_INFLIGHT)) credit_cnt <= credit_cnt + CNT_W'(1);
        2'b01:   credit_cnt <= credit_cnt - CNT_W'(1);
        default: credit_cnt <= credit_cnt;
      endcase
    end
  end

  assign hp_rd        = (state == ST_FETCH);
  assign tx_hp_valid  = offer_valid;
  assign tx_hp_seq    = offer_q.seq;
  assign tx_hp_word_0 = offer_q.data[31:0];
  assign tx_hp_word_1 = offer_q.data[63:32];
  assign tx_hp_word_2 = offer_q.data[95:64];

endmodule

// File: tb/tb_usb3_hp_tx_sched.sv
// Self-checking bench for usb3_hp_tx_sched: directed sequences, a control-pulse
// vector table and a randomized run checked against an in-order header model.
module tb_usb3_hp_tx_sched;
  import usb3_hp_tx_sched_pkg::*;

  typedef struct {
    logic       lgood;
    logic [2:0] lseq;
    logic       lcrd;
    logic       cinit;
    logic [2:0] exp_inflight;
    logic [2:0] exp_credit;
    logic       exp_err;
  } vec_t;

  typedef enum int {P_LGOOD, P_LBAD, P_LCRD, P_CINIT} pulse_e;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hp_empty, hp_rd;
  logic        tx_hp_valid, tx_hp_ready = 1'b1;
  logic [31:0] tx_hp_word_0, tx_hp_word_1, tx_hp_word_2;
  logic [2:0]  tx_hp_seq;
  logic        lgood_valid = 1'b0, lbad_valid = 1'b0, lcrd_valid = 1'b0;
  logic        credit_init = 1'b0, link_active = 1'b1;
  logic [2:0]  lgood_seq = '0;
  logic [2:0]  inflight_cnt, credit_cnt;
  logic        seq_err;

  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  // TX FIFO model: read data appears the cycle after the strobe.
  logic [95:0] fifo_mem [0:255];
  int          wr_idx = 0, rd_idx = 0, rd_empty_err = 0;
  logic [95:0] hp_q = '0;
  assign hp_empty = (wr_idx == rd_idx);

  always @(posedge clk) begin
    if (hp_rd) begin
      if (wr_idx == rd_idx) rd_empty_err <= rd_empty_err + 1;
      else begin
        hp_q   <= fifo_mem[rd_idx];
        rd_idx <= rd_idx + 1;
      end
    end
  end

  usb3_hp_tx_sched dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hp_empty     (hp_empty),
    .hp_rd        (hp_rd),
    .hp_word_0_q  (hp_q[31:0]),
    .hp_word_1_q  (hp_q[63:32]),
    .hp_word_2_q  (hp_q[95:64]),
    .tx_hp_valid  (tx_hp_valid),
    .tx_hp_ready  (tx_hp_ready),
    .tx_hp_word_0 (tx_hp_word_0),
    .tx_hp_word_1 (tx_hp_word_1),
    .tx_hp_word_2 (tx_hp_word_2),
    .tx_hp_seq    (tx_hp_seq),
    .lgood_valid  (lgood_valid),
    .lgood_seq    (lgood_seq),
    .lbad_valid   (lbad_valid),
    .lcrd_valid   (lcrd_valid),
    .credit_init  (credit_init),
    .link_active  (link_active),
    .inflight_cnt (inflight_cnt),
    .credit_cnt   (credit_cnt),
    .seq_err      (seq_err)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: records accepted headers and checks that a held offer never changes.
  hp_entry_t got[$];
  hp_entry_t cur_offer, prev_offer;
  logic      prev_hold = 1'b0;
  int        n_seq_err = 0;
  assign cur_offer = '{seq: tx_hp_seq, data: {tx_hp_word_2, tx_hp_word_1, tx_hp_word_0}};

  always @(negedge clk) begin
    if (!rst_n) prev_hold = 1'b0;
    else begin
      if (prev_hold) begin
        check("hold_valid", 128'(tx_hp_valid), 128'(1));
        check("hold_data", 128'(cur_offer), 128'(prev_offer));
      end
      if (tx_hp_valid && tx_hp_ready) got.push_back(cur_offer);
      if (seq_err) n_seq_err++;
      prev_hold  = tx_hp_valid && !tx_hp_ready;
      prev_offer = cur_offer;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_hdr(input int n);
    for (int i = 0; i < n; i++) begin
      fifo_mem[wr_idx] = {$urandom, $urandom, $urandom};
      wr_idx++;
    end
  endtask

  task automatic pulse(input pulse_e kind, input logic [2:0] seq);
    step();
    case (kind)
      P_LGOOD: begin lgood_valid = 1'b1; lgood_seq = seq; end
      P_LBAD:  lbad_valid  = 1'b1;
      P_LCRD:  lcrd_valid  = 1'b1;
      default: credit_init = 1'b1;
    endcase
    step();
    lgood_valid = 1'b0; lbad_valid = 1'b0; lcrd_valid = 1'b0; credit_init = 1'b0;
  endtask

  task automatic wait_got(input int n, input int budget, input string name);
    int c = 0;
    while (got.size() < n && c < budget) begin
      @(posedge clk);
      c++;
    end
    check(name, 128'(got.size()), 128'(n));
  endtask

  task automatic check_entry(input string name, input int k, input int idx, input int seq);
    hp_entry_t e;
    e.seq  = 3'(seq);
    e.data = fifo_mem[idx];
    if (k < got.size()) check(name, 128'(got[k]), 128'(e));
    else check({name, "_missing"}, 128'(got.size()), 128'(k + 1));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tx_hp_ready = 1'b1; link_active = 1'b1;
    lgood_valid = 1'b0; lbad_valid = 1'b0; lcrd_valid = 1'b0; credit_init = 1'b0;
    repeat (3) @(posedge clk);
    got.delete();
    n_seq_err = 0;
    #1 rst_n = 1'b1;
  endtask

  initial begin
    vec_t      tbl[10];
    hp_entry_t e;
    int        base, c, acked, exp_err;
    bit        done;
    localparam int N_RAND = 40;

    // ---------------- reset state
    do_reset();
    @(negedge clk);
    check("rst_hp_rd", 128'(hp_rd), 128'(0));
    check("rst_valid", 128'(tx_hp_valid), 128'(0));
    check("rst_inflight", 128'(inflight_cnt), 128'(0));
    check("rst_credit", 128'(credit_cnt), 128'(4));
    check("rst_seq_err", 128'(seq_err), 128'(0));
    check("rst_offer", 128'(cur_offer), 128'(0));

    // ---------------- three headers, then control-pulse vector table
    step();
    base = wr_idx;
    push_hdr(3);
    wait_got(3, 60, "t1_sent");
    for (int k = 0; k < 3; k++) check_entry("t1_hdr", k, base + k, k);
    repeat (3) step();
    @(negedge clk);
    check("t1_inflight", 128'(inflight_cnt), 128'(3));
    check("t1_credit", 128'(credit_cnt), 128'(1));

    tbl[0] = '{1'b1, 3'd0, 1'b0, 1'b0, 3'd2, 3'd1, 1'b0};
    tbl[1] = '{1'b1, 3'd0, 1'b0, 1'b0, 3'd2, 3'd1, 1'b1};
    tbl[2] = '{1'b0, 3'd0, 1'b1, 1'b0, 3'd2, 3'd2, 1'b0};
    tbl[3] = '{1'b1, 3'd1, 1'b1, 1'b0, 3'd1, 3'd3, 1'b0};
    tbl[4] = '{1'b0, 3'd0, 1'b1, 1'b1, 3'd1, 3'd4, 1'b0};
    tbl[5] = '{1'b0, 3'd0, 1'b1, 1'b0, 3'd1, 3'd4, 1'b0};
    tbl[6] = '{1'b1, 3'd7, 1'b0, 1'b0, 3'd1, 3'd4, 1'b1};
    tbl[7] = '{1'b1, 3'd2, 1'b0, 1'b0, 3'd0, 3'd4, 1'b0};
    tbl[8] = '{1'b1, 3'd3, 1'b0, 1'b0, 3'd0, 3'd4, 1'b1};
    tbl[9] = '{1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 3'd4, 1'b0};
    for (int i = 0; i < 10; i++) begin
      step();
      lgood_valid = tbl[i].lgood; lgood_seq = tbl[i].lseq;
      lcrd_valid = tbl[i].lcrd; credit_init = tbl[i].cinit;
      step();
      lgood_valid = 1'b0; lcrd_valid = 1'b0; credit_init = 1'b0;
      @(negedge clk);
      check($sformatf("tbl%0d_inflight", i), 128'(inflight_cnt), 128'(tbl[i].exp_inflight));
      check($sformatf("tbl%0d_credit", i), 128'(credit_cnt), 128'(tbl[i].exp_credit));
      check($sformatf("tbl%0d_seq_err", i), 128'(seq_err), 128'(tbl[i].exp_err));
    end

    // ---------------- credit exhaustion stops FIFO reads
    do_reset();
    base = wr_idx;
    push_hdr(6);
    wait_got(4, 60, "t2_first4");
    repeat (20) step();
    @(negedge clk);
    check("t2_sent_only4", 128'(got.size()), 128'(4));
    check("t2_fifo_reads", 128'(rd_idx - base), 128'(4));
    check("t2_inflight", 128'(inflight_cnt), 128'(4));
    check("t2_credit", 128'(credit_cnt), 128'(0));
    pulse(P_LGOOD, 3'd0);
    pulse(P_LGOOD, 3'd1);
    pulse(P_LCRD, 3'd0);
    pulse(P_LCRD, 3'd0);
    wait_got(6, 60, "t2_all6");
    check_entry("t2_hdr5", 4, base + 4, 4);
    check_entry("t2_hdr6", 5, base + 5, 5);

    // ---------------- LBAD replays unacknowledged headers
    do_reset();
    base = wr_idx;
    push_hdr(3);
    wait_got(3, 60, "t3_sent");
    pulse(P_LGOOD, 3'd0);
    pulse(P_LBAD, 3'd0);
    wait_got(5, 60, "t3_replay");
    check_entry("t3_replay1", 3, base + 1, 1);
    check_entry("t3_replay2", 4, base + 2, 2);
    @(negedge clk);
    check("t3_credit", 128'(credit_cnt), 128'(1));
    check("t3_inflight", 128'(inflight_cnt), 128'(2));
    step();
    push_hdr(1);
    wait_got(6, 60, "t3_new");
    check_entry("t3_new_seq3", 5, base + 3, 3);

    // ---------------- unexpected LGOOD sequence
    do_reset();
    base = wr_idx;
    push_hdr(1);
    wait_got(1, 60, "t4_sent");
    pulse(P_LGOOD, 3'd5);
    @(negedge clk);
    check("t4_seq_err_hi", 128'(seq_err), 128'(1));
    @(negedge clk);
    check("t4_seq_err_lo", 128'(seq_err), 128'(0));
    check("t4_inflight", 128'(inflight_cnt), 128'(1));
    pulse(P_LGOOD, 3'd0);

    // ---------------- randomized traffic vs in-order reference model
    do_reset();
    base = wr_idx;
    push_hdr(N_RAND);
    acked = 0; exp_err = 0; done = 1'b0;
    fork
      begin
        while (!done) begin
          step();
          tx_hp_ready = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        c = 0;
        while (acked < N_RAND && c < 4000) begin
          step();
          c++;
          lgood_valid = 1'b0; lcrd_valid = 1'b0;
          if ($urandom_range(0, 9) == 0) begin
            lgood_valid = 1'b1; lgood_seq = 3'((acked + 3) % 8); exp_err++;
          end else if (got.size() > acked && $urandom_range(0, 2) == 0) begin
            lgood_valid = 1'b1; lgood_seq = 3'(acked % 8); lcrd_valid = 1'b1; acked++;
          end
        end
        step();
        lgood_valid = 1'b0; lcrd_valid = 1'b0;
        done = 1'b1;
      end
    join
    tx_hp_ready = 1'b1;
    check("rand_all_acked", 128'(acked), 128'(N_RAND));
    repeat (5) step();
    @(negedge clk);
    check("rand_sent", 128'(got.size()), 128'(N_RAND));
    for (int k = 0; k < N_RAND; k++) check_entry($sformatf("rand_hdr%0d", k), k, base + k, k % 8);
    check("rand_seq_err_cnt", 128'(n_seq_err), 128'(exp_err));
    check("rand_inflight", 128'(inflight_cnt), 128'(0));
    check("rand_credit", 128'(credit_cnt), 128'(4));

    // ---------------- stall with link drop, then replay on link return
    do_reset();
    tx_hp_ready = 1'b0;
    base = wr_idx;
    push_hdr(2);
    c = 0;
    @(negedge clk);
    while (!tx_hp_valid && c < 30) begin
      @(negedge clk);
      c++;
    end
    e = '{seq: 3'd0, data: fifo_mem[base]};
    check("t6_valid", 128'(tx_hp_valid), 128'(1));
    check("t6_offer", 128'(cur_offer), 128'(e));
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 0) link_active = 1'b0;
      @(negedge clk);
      check("t6_stall_valid", 128'(tx_hp_valid), 128'(1));
      check("t6_stall_data", 128'(cur_offer), 128'(e));
    end
    step();
    tx_hp_ready = 1'b1;
    wait_got(1, 10, "t6_accept");
    repeat (10) step();
    @(negedge clk);
    check("t6_idle_valid", 128'(tx_hp_valid), 128'(0));
    check("t6_idle_count", 128'(got.size()), 128'(1));
    check("t6_idle_reads", 128'(rd_idx - base), 128'(1));
    step();
    link_active = 1'b1;
    wait_got(3, 60, "t6_after_link");
    check_entry("t6_orig", 0, base, 0);
    check_entry("t6_replay", 1, base, 0);
    check_entry("t6_next", 2, base + 1, 1);

    check("fifo_read_when_empty", 128'(rd_empty_err), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
